// File: rtl/tis_mem_node_if.sv
// Request/acknowledge bus between a tis_mem_node and its attached nodes.
// master = the node array side, slave = the memory node.
interface tis_mem_node_if #(
   parameter int unsigned WIDTH  = 11,
   parameter int unsigned NPORTS = 4,
   parameter int unsigned DEPTH  = 15
) ();
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [NPORTS-1:0]       push_req;
   logic [NPORTS*WIDTH-1:0] push_data;
   logic [NPORTS-1:0]       push_ack;
   logic [NPORTS-1:0]       pop_req;
   logic [NPORTS-1:0]       pop_ack;
   logic [WIDTH-1:0]        pop_data;
   logic [CW-1:0]           count;
   logic                    empty;
   logic                    full;

   modport master (
      output push_req, push_data, pop_req,
      input  push_ack, pop_ack, pop_data, count, empty, full
   );

   modport slave (
      input  push_req, push_data, pop_req,
      output push_ack, pop_ack, pop_data, count, empty, full
   );
endinterface

// File: rtl/tis_mem_node.sv
// Shared LIFO/FIFO memory node: one push and one pop per cycle, each chosen
// by its own round-robin arbiter across NPORTS blocking req/ack ports.
module tis_mem_node #(
   parameter int unsigned WIDTH  = 11,
   parameter int unsigned DEPTH  = 15,
   parameter int unsigned NPORTS = 4,
   parameter int unsigned MODE   = 0
) (
   input  logic           clk,
   input  logic           rst,
   tis_mem_node_if.slave  bus
);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

   logic [WIDTH-1:0]  mem_q [DEPTH];
   logic [CW-1:0]     count_q, count_d;
   logic              empty_q, empty_d;
   logic              full_q, full_d;
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]     push_ptr_q, push_ptr_d;
   logic [PW-1:0]     pop_ptr_q, pop_ptr_d;

   logic              push_go_c, pop_go_c;
   logic [PW-1:0]     push_sel_c, pop_sel_c;
   logic [NPORTS-1:0] push_ack_c, pop_ack_c;
   logic [AW-1:0]     wr_idx_c, rd_idx_c;
   logic [WIDTH-1:0]  wr_data_c;

   // First requester at or above ptr, wrapping; MSB of result flags a hit.
   function automatic logic [PW:0] rr_pick(input logic [NPORTS-1:0] req,
                                           input logic [PW-1:0]     ptr);
      logic [PW:0] pick;
      int unsigned k;
      pick = '0;
      for (int unsigned i = 0; i < NPORTS; i++) begin
         k = 32'(ptr) + i;
         if (k >= NPORTS) k = k - NPORTS;
         if (!pick[PW] && req[PW'(k)]) pick = {1'b1, PW'(k)};
      end
      return pick;
   endfunction

   function automatic logic [PW-1:0] port_inc(input logic [PW-1:0] p);
      return (32'(p) == NPORTS - 1) ? '0 : PW'(32'(p) + 1);
   endfunction

   function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
      return (32'(a) == DEPTH - 1) ? '0 : AW'(32'(a) + 1);
   endfunction

   // Grants depend only on requests, arbiter pointers and registered count.
   always_comb begin
      push_go_c  = 1'b0;
      push_sel_c = '0;
      pop_go_c   = 1'b0;
      pop_sel_c  = '0;
      push_ack_c = '0;
      pop_ack_c  = '0;
      if (!rst && !full_q)  {push_go_c, push_sel_c} = rr_pick(bus.push_req, push_ptr_q);
      if (!rst && !empty_q) {pop_go_c, pop_sel_c}   = rr_pick(bus.pop_req, pop_ptr_q);
      if (push_go_c) push_ack_c[push_sel_c] = 1'b1;
      if (pop_go_c)  pop_ack_c[pop_sel_c]   = 1'b1;
   end

   // Storage addressing; a stack push racing a pop overwrites the old top.
   always_comb begin
      wr_data_c = bus.push_data[push_sel_c*WIDTH +: WIDTH];
      if (MODE == 0) begin
         wr_idx_c = AW'(pop_go_c ? count_q - 1'b1 : count_q);
         rd_idx_c = AW'(count_q - 1'b1);
      end else begin
         wr_idx_c = wr_ptr_q;
         rd_idx_c = rd_ptr_q;
      end
   end

   always_comb begin
      count_d    = count_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      push_ptr_d = push_ptr_q;
      pop_ptr_d  = pop_ptr_q;
      if (push_go_c && !pop_go_c)      count_d = count_q + 1'b1;
      else if (!push_go_c && pop_go_c) count_d = count_q - 1'b1;
      if (MODE != 0 && push_go_c) wr_ptr_d = addr_inc(wr_ptr_q);
      if (MODE != 0 && pop_go_c)  rd_ptr_d = addr_inc(rd_ptr_q);
      if (push_go_c) push_ptr_d = port_inc(push_sel_c);
      if (pop_go_c)  pop_ptr_d  = port_inc(pop_sel_c);
      empty_d = (count_d == '0);
      full_d  = (count_d == CW'(DEPTH));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q    <= '0;
         empty_q    <= 1'b1;
         full_q     <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         push_ptr_q <= '0;
         pop_ptr_q  <= '0;
      end else begin
         count_q    <= count_d;
         empty_q    <= empty_d;
         full_q     <= full_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         push_ptr_q <= push_ptr_d;
         pop_ptr_q  <= pop_ptr_d;
      end
   end

   // Contents need no reset; push_go_c is already suppressed during rst.
   always_ff @(posedge clk) begin
      if (push_go_c) mem_q[wr_idx_c] <= wr_data_c;
   end

   assign bus.push_ack = push_ack_c;
   assign bus.pop_ack  = pop_ack_c;
   assign bus.pop_data = empty_q ? '0 : mem_q[rd_idx_c];
   assign bus.count    = count_q;
   assign bus.empty    = empty_q;
   assign bus.full     = full_q;
endmodule

// File: tb/tb_tis_mem_node.sv
// Bench for tis_mem_node: a stack and a queue instance side by side, checked
// against queue-based reference models plus directed tables and sequences.
module tb_tis_mem_node;
   localparam int W = 11;
   localparam int D = 15;
   localparam int N = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   tis_mem_node_if #(.WIDTH(W), .NPORTS(N), .DEPTH(D)) bs ();
   tis_mem_node_if #(.WIDTH(W), .NPORTS(N), .DEPTH(D)) bq ();

   tis_mem_node #(.WIDTH(W), .DEPTH(D), .NPORTS(N), .MODE(0)) u_stk (
      .clk(clk), .rst(rst), .bus(bs));
   tis_mem_node #(.WIDTH(W), .DEPTH(D), .NPORTS(N), .MODE(1)) u_que (
      .clk(clk), .rst(rst), .bus(bq));

   int n_vec = 0;
   int n_bad = 0;

   // Reference model: contents as plain queues, arbiter pointers as ints.
   int mq_s[$];
   int mq_q[$];
   int push_ptr_m[2];
   int pop_ptr_m[2];
   int pu_g[2];
   int po_g[2];
   logic [N*W-1:0] pd_m[2];

   typedef struct {
      logic [3:0]  pu;
      logic [3:0]  po;
      logic [10:0] d;
      logic [3:0]  e_pu;
      logic [3:0]  e_po;
      int          e_cnt;
      logic [10:0] e_data;
   } vec_t;

   vec_t tbl[14];

   function automatic vec_t mk(input logic [3:0] pu, input logic [3:0] po,
                               input logic [10:0] d, input logic [3:0] e_pu,
                               input logic [3:0] e_po, input int e_cnt,
                               input logic [10:0] e_data);
      vec_t v;
      v.pu = pu; v.po = po; v.d = d; v.e_pu = e_pu; v.e_po = e_po;
      v.e_cnt = e_cnt; v.e_data = e_data;
      return v;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int arb(input logic [3:0] req, input int ptr, input bit ok);
      if (!ok) return -1;
      for (int i = 0; i < N; i++) begin
         int p;
         p = (ptr + i) % N;
         if (req[2'(p)]) return p;
      end
      return -1;
   endfunction

   function automatic int oh(input int g);
      return (g < 0) ? 0 : (1 << g);
   endfunction

   task automatic cmp_dut(input string nm, input int d, input logic [3:0] pa,
                          input logic [3:0] oa, input logic [10:0] pdat,
                          input logic [3:0] cnt, input logic emp, input logic ful);
      int sz;
      int topv;
      sz   = (d == 0) ? mq_s.size() : mq_q.size();
      topv = 0;
      if (sz > 0) topv = (d == 0) ? mq_s[sz-1] : mq_q[0];
      chk({nm, ".push_ack"}, int'(pa), oh(pu_g[d]));
      chk({nm, ".pop_ack"}, int'(oa), oh(po_g[d]));
      chk({nm, ".pop_data"}, int'(pdat), topv);
      chk({nm, ".count"}, int'(cnt), sz);
      chk({nm, ".empty"}, int'(emp), int'(sz == 0));
      chk({nm, ".full"}, int'(ful), int'(sz == D));
   endtask

   // Apply one cycle of inputs, then compare both DUTs to the model at negedge.
   task automatic drive(input logic [3:0] pus, input logic [N*W-1:0] pds,
                        input logic [3:0] pos, input logic [3:0] puq,
                        input logic [N*W-1:0] pdq, input logic [3:0] poq,
                        input logic r);
      rst          = r;
      bs.push_req  = pus; bs.push_data = pds; bs.pop_req = pos;
      bq.push_req  = puq; bq.push_data = pdq; bq.pop_req = poq;
      pd_m[0] = pds;
      pd_m[1] = pdq;
      if (r) begin
         mq_s.delete();
         mq_q.delete();
         push_ptr_m = '{0, 0};
         pop_ptr_m  = '{0, 0};
      end
      pu_g[0] = arb(pus, push_ptr_m[0], !r && mq_s.size() < D);
      po_g[0] = arb(pos, pop_ptr_m[0],  !r && mq_s.size() > 0);
      pu_g[1] = arb(puq, push_ptr_m[1], !r && mq_q.size() < D);
      po_g[1] = arb(poq, pop_ptr_m[1],  !r && mq_q.size() > 0);
      @(negedge clk);
      cmp_dut("stk", 0, bs.push_ack, bs.pop_ack, bs.pop_data, bs.count, bs.empty, bs.full);
      cmp_dut("que", 1, bq.push_ack, bq.pop_ack, bq.pop_data, bq.count, bq.empty, bq.full);
   endtask

   // Commit the granted transfers after the rising edge: pop first, then push.
   task automatic advance();
      @(posedge clk);
      #1;
      if (!rst) begin
         for (int d = 0; d < 2; d++) begin
            if (po_g[d] >= 0) begin
               if (d == 0) void'(mq_s.pop_back());
               else        void'(mq_q.pop_front());
               pop_ptr_m[d] = (po_g[d] + 1) % N;
            end
            if (pu_g[d] >= 0) begin
               int v;
               v = int'(pd_m[d][pu_g[d]*W +: W]);
               if (d == 0) mq_s.push_back(v);
               else        mq_q.push_back(v);
               push_ptr_m[d] = (pu_g[d] + 1) % N;
            end
         end
      end
   endtask

   initial begin
      logic [N*W-1:0] rr_data;
      logic [3:0] rr_exp[4];
      tbl[0]  = mk(4'b0001, 4'b0000, 11'd5,       4'b0001, 4'b0000, 0, 11'd0);
      tbl[1]  = mk(4'b0001, 4'b0000, 11'd12,      4'b0001, 4'b0000, 1, 11'd5);
      tbl[2]  = mk(4'b0001, 4'b0000, 11'(-999),   4'b0001, 4'b0000, 2, 11'd12);
      tbl[3]  = mk(4'b0000, 4'b0100, 11'd0,       4'b0000, 4'b0100, 3, 11'(-999));
      tbl[4]  = mk(4'b0000, 4'b0100, 11'd0,       4'b0000, 4'b0100, 2, 11'd12);
      tbl[5]  = mk(4'b0000, 4'b0100, 11'd0,       4'b0000, 4'b0100, 1, 11'd5);
      tbl[6]  = mk(4'b0001, 4'b0100, 11'd9,       4'b0001, 4'b0000, 0, 11'd0);
      tbl[7]  = mk(4'b0001, 4'b0000, 11'd8,       4'b0001, 4'b0000, 1, 11'd9);
      tbl[8]  = mk(4'b0001, 4'b0000, 11'd7,       4'b0001, 4'b0000, 2, 11'd8);
      tbl[9]  = mk(4'b0010, 4'b1000, 11'd42,      4'b0010, 4'b1000, 3, 11'd7);
      tbl[10] = mk(4'b0000, 4'b0000, 11'd0,       4'b0000, 4'b0000, 3, 11'd42);
      tbl[11] = mk(4'b0001, 4'b0000, 11'd50,      4'b0001, 4'b0000, 3, 11'd42);
      tbl[12] = mk(4'b0001, 4'b0000, 11'd60,      4'b0001, 4'b0000, 4, 11'd50);
      tbl[13] = mk(4'b0000, 4'b0000, 11'd0,       4'b0000, 4'b0000, 5, 11'd60);

      // Power-up reset, with requests present to show acks are held low.
      drive('0, '0, '0, '0, '0, '0, 1'b1);
      advance();
      drive(4'b1111, '0, 4'b1111, 4'b1111, '0, 4'b1111, 1'b1);
      chk("rst.push_ack", int'(bs.push_ack), 0);
      chk("rst.empty", int'(bq.empty), 1);
      advance();

      // Stack order, empty-edge push/pop and simultaneous push/pop.
      foreach (tbl[i]) begin
         drive(tbl[i].pu, {4{tbl[i].d}}, tbl[i].po, '0, '0, '0, 1'b0);
         chk($sformatf("tbl%0d.push_ack", i), int'(bs.push_ack), int'(tbl[i].e_pu));
         chk($sformatf("tbl%0d.pop_ack", i), int'(bs.pop_ack), int'(tbl[i].e_po));
         chk($sformatf("tbl%0d.count", i), int'(bs.count), tbl[i].e_cnt);
         chk($sformatf("tbl%0d.pop_data", i), int'(bs.pop_data), int'(tbl[i].e_data));
         advance();
      end

      // Queue: fill, refuse on full, pop while full, wrap the write pointer, drain.
      for (int v = 1; v <= 15; v++) begin
         drive('0, '0, '0, 4'b0010, {4{11'(v)}}, '0, 1'b0);
         chk("qfill.push_ack", int'(bq.push_ack), 2);
         advance();
      end
      drive('0, '0, '0, 4'b0010, {4{11'd16}}, '0, 1'b0);
      chk("qfull.full", int'(bq.full), 1);
      chk("qfull.push_ack", int'(bq.push_ack), 0);
      advance();
      for (int k = 1; k <= 3; k++) begin
         drive('0, '0, '0, (k == 1) ? 4'b0010 : 4'b0000, {4{11'd16}}, 4'b0001, 1'b0);
         chk("qpop.push_ack", int'(bq.push_ack), 0);
         chk("qpop.pop_ack", int'(bq.pop_ack), 1);
         chk("qpop.pop_data", int'(bq.pop_data), k);
         chk("qpop.count", int'(bq.count), 16 - k);
         advance();
      end
      for (int v = 16; v <= 18; v++) begin
         drive('0, '0, '0, 4'b0010, {4{11'(v)}}, '0, 1'b0);
         chk("qwrap.push_ack", int'(bq.push_ack), 2);
         advance();
      end
      for (int v = 4; v <= 18; v++) begin
         drive('0, '0, '0, '0, '0, 4'b1000, 1'b0);
         chk("qdrain.pop_data", int'(bq.pop_data), v);
         chk("qdrain.pop_ack", int'(bq.pop_ack), 8);
         advance();
      end
      drive('0, '0, '0, '0, '0, '0, 1'b0);
      chk("qdrain.empty", int'(bq.empty), 1);
      advance();

      // Mid-traffic reset with the stack holding five entries.
      drive(4'b0001, {4{11'd70}}, 4'b0100, '0, '0, '0, 1'b1);
      chk("mrst.push_ack", int'(bs.push_ack), 0);
      chk("mrst.pop_ack", int'(bs.pop_ack), 0);
      chk("mrst.count", int'(bs.count), 0);
      advance();
      drive(4'b0001, {4{11'd70}}, 4'b0100, '0, '0, '0, 1'b1);
      advance();
      drive('0, '0, '0, '0, '0, '0, 1'b0);
      chk("mrst.empty", int'(bs.empty), 1);
      chk("mrst.pop_data", int'(bs.pop_data), 0);
      advance();

      // Round robin from freshly reset arbiters.
      rr_data = {11'd400, 11'd300, 11'd200, 11'd100};
      for (int k = 0; k < 4; k++) begin
         drive('0, '0, '0, 4'b1111, rr_data, '0, 1'b0);
         chk($sformatf("rr4.%0d", k), int'(bq.push_ack), 1 << k);
         advance();
      end
      rr_exp = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
      for (int k = 0; k < 4; k++) begin
         drive('0, '0, '0, 4'b0101, rr_data, '0, 1'b0);
         chk($sformatf("rr2.%0d", k), int'(bq.push_ack), int'(rr_exp[k]));
         advance();
      end
      drive('0, '0, '0, '0, '0, '0, 1'b0);
      chk("rr.count", int'(bq.count), 8);
      chk("rr.pop_data", int'(bq.pop_data), 100);
      advance();

      // Random traffic, alternating fill-biased and drain-biased phases.
      for (int c = 0; c < 1600; c++) begin
         logic [3:0] pus, pos, puq, poq;
         logic [N*W-1:0] pds, pdq;
         bit fill;
         fill = ((c / 200) % 2) == 0;
         pus = 4'($urandom); pos = 4'($urandom);
         puq = 4'($urandom); poq = 4'($urandom);
         if (fill) begin pos = pos & 4'($urandom); poq = poq & 4'($urandom); end
         else      begin pus = pus & 4'($urandom); puq = puq & 4'($urandom); end
         pds = {4{11'($urandom)}} ^ {11'($urandom), 11'($urandom), 11'($urandom), 11'($urandom)};
         pdq = {11'($urandom), 11'($urandom), 11'($urandom), 11'($urandom)};
         drive(pus, pds, pos, puq, pdq, poq, $urandom_range(0, 299) == 0);
         advance();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
